// File: rtl/mesi_isc_pkg.sv
// rtl/mesi_isc_pkg.sv - shared bus encodings, MESI line state and FSM state types
package mesi_isc_pkg;

  localparam logic [2:0] MBUS_NOP      = 3'd0;
  localparam logic [2:0] MBUS_WR       = 3'd1;
  localparam logic [2:0] MBUS_RD       = 3'd2;
  localparam logic [2:0] MBUS_WR_BROAD = 3'd3;
  localparam logic [2:0] MBUS_RD_BROAD = 3'd4;

  localparam logic [2:0] CBUS_NOP      = 3'd0;
  localparam logic [2:0] CBUS_WR_SNOOP = 3'd1;
  localparam logic [2:0] CBUS_RD_SNOOP = 3'd2;
  localparam logic [2:0] CBUS_EN_WR    = 3'd3;
  localparam logic [2:0] CBUS_EN_RD    = 3'd4;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_BROAD   = 3'd2,
    ST_WAIT_EN = 3'd3,
    ST_ACCESS  = 3'd4,
    ST_DONE    = 3'd5
  } main_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2,
    S_GUARD = 2'd3
  } snoop_state_t;

endpackage

// File: rtl/mesi_isc_cpu_agent_snoop.sv
// rtl/mesi_isc_cpu_agent_snoop.sv - coherence bus responder: latches a command, acks after SNOOP_LAT cycles
module mesi_isc_cpu_agent_snoop
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 2,
  parameter int SNOOP_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  i_cmd,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  mesi_t                       i_line_state,
  input  logic [ADDR_WIDTH-IDX_W-1:0] i_line_tag,
  output logic                        o_ack,
  output logic [2:0]                  o_cmd,
  output logic [ADDR_WIDTH-1:0]       o_addr,
  output logic                        o_upd_en,
  output mesi_t                       o_upd_state
);

  // S_WAIT lasts SNOOP_LAT-1 cycles; the counter starts at 0 on entry
  localparam logic [2:0] LAT_M2 = 3'(SNOOP_LAT - 2);

  snoop_state_t          r_state;
  snoop_state_t          w_next;
  logic [2:0]            r_cnt;
  logic [2:0]            r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cmd   <= CBUS_NOP;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_cmd != CBUS_NOP) begin
        r_cmd  <= i_cmd;
        r_addr <= i_addr;
        r_cnt  <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_cmd != CBUS_NOP) w_next = (SNOOP_LAT == 1) ? S_ACK : S_WAIT;
      S_WAIT:  if (r_cnt == LAT_M2) w_next = S_ACK;
      S_ACK:   w_next = S_GUARD;
      S_GUARD: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_hit       = (i_line_state != MESI_I) && (i_line_tag == r_addr[ADDR_WIDTH-1:IDX_W]);
  assign o_ack       = (r_state == S_ACK);
  assign o_cmd       = r_cmd;
  assign o_addr      = r_addr;
  assign o_upd_en    = o_ack && w_hit &&
                       ((r_cmd == CBUS_WR_SNOOP) ||
                        (r_cmd == CBUS_RD_SNOOP && (i_line_state == MESI_E || i_line_state == MESI_M)));
  assign o_upd_state = (r_cmd == CBUS_WR_SNOOP) ? MESI_I : MESI_S;

endmodule

// File: rtl/mesi_isc_cpu_agent.sv
// rtl/mesi_isc_cpu_agent.sv - MESI CPU agent: direct-mapped line states, main bus requester, snoop responder
module mesi_isc_cpu_agent
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 4,
  parameter int SNOOP_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  done_o,
  output logic [2:0]            mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0] mbus_addr_o,
  input  logic                  mbus_ack_i,
  input  logic [2:0]            cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
  output logic                  cbus_ack_o,
  output logic                  err_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  mesi_t                 r_line_state [NUM_LINES];
  logic [TAG_W-1:0]      r_line_tag   [NUM_LINES];

  main_state_t           r_state;
  main_state_t           w_next;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_mbus_cmd;
  logic [ADDR_WIDTH-1:0] r_mbus_addr;
  logic                  r_err;
  logic                  r_live;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  mesi_t                 w_cur_state;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_lookup_done;
  logic                  w_fill;

  logic                  w_snp_ack;
  logic [2:0]            w_snp_cmd;
  logic [ADDR_WIDTH-1:0] w_snp_addr;
  logic [IDX_W-1:0]      w_snp_idx;
  logic                  w_snp_upd;
  mesi_t                 w_snp_upd_state;
  logic                  w_en_cmd;
  logic                  w_en_match;
  logic                  w_bad_cmd;

  assign w_idx         = r_addr[IDX_W-1:0];
  assign w_tag         = r_addr[ADDR_WIDTH-1:IDX_W];
  assign w_cur_state   = r_line_state[w_idx];
  assign w_hit         = (w_cur_state != MESI_I) && (r_line_tag[w_idx] == w_tag);
  assign w_accept      = req_valid_i && req_ready_o;
  assign w_lookup_done = (r_state == ST_LOOKUP) && w_hit &&
                         (!r_wr || w_cur_state == MESI_E || w_cur_state == MESI_M);
  assign w_fill        = (r_state == ST_ACCESS) && mbus_ack_i;

  assign w_snp_idx  = w_snp_addr[IDX_W-1:0];
  assign w_en_cmd   = (w_snp_cmd == CBUS_EN_WR) || (w_snp_cmd == CBUS_EN_RD);
  assign w_bad_cmd  = (w_snp_cmd > CBUS_EN_RD);
  assign w_en_match = w_snp_ack && (r_state == ST_WAIT_EN) && (w_snp_addr == r_addr) &&
                      (r_wr ? (w_snp_cmd == CBUS_EN_WR) : (w_snp_cmd == CBUS_EN_RD));

  mesi_isc_cpu_agent_snoop #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W),
    .SNOOP_LAT  (SNOOP_LAT)
  ) u_snoop (
    .clk          (clk),
    .rst          (rst),
    .i_cmd        (cbus_cmd_i),
    .i_addr       (cbus_addr_i),
    .i_line_state (r_line_state[w_snp_idx]),
    .i_line_tag   (r_line_tag[w_snp_idx]),
    .o_ack        (w_snp_ack),
    .o_cmd        (w_snp_cmd),
    .o_addr       (w_snp_addr),
    .o_upd_en     (w_snp_upd),
    .o_upd_state  (w_snp_upd_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_LOOKUP;
      ST_LOOKUP:  w_next = w_lookup_done ? ST_DONE : ST_BROAD;
      ST_BROAD:   if (mbus_ack_i) w_next = ST_WAIT_EN;
      ST_WAIT_EN: if (w_en_match) w_next = ST_ACCESS;
      ST_ACCESS:  if (mbus_ack_i) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_mbus_cmd  <= MBUS_NOP;
      r_mbus_addr <= '0;
      r_err       <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_wr   <= req_wr_i;
        r_addr <= req_addr_i;
      end
      if (r_state == ST_LOOKUP && !w_lookup_done) begin
        r_mbus_cmd  <= r_wr ? MBUS_WR_BROAD : MBUS_RD_BROAD;
        r_mbus_addr <= r_addr;
      end
      if (w_en_match) r_mbus_cmd <= r_wr ? MBUS_WR : MBUS_RD;
      if ((r_state == ST_BROAD || r_state == ST_ACCESS) && mbus_ack_i) r_mbus_cmd <= MBUS_NOP;
      if (w_snp_ack && ((w_en_cmd && !w_en_match) || w_bad_cmd)) r_err <= 1'b1;
    end
  end

  // Snoop update is written first so a same-cycle local completion on the same line wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_line_state[i] <= MESI_I;
        r_line_tag[i]   <= '0;
      end
    end else begin
      if (w_snp_upd) r_line_state[w_snp_idx] <= w_snp_upd_state;
      if (w_lookup_done && r_wr) r_line_state[w_idx] <= MESI_M;
      if (w_fill) begin
        r_line_state[w_idx] <= r_wr ? MESI_M : MESI_S;
        r_line_tag[w_idx]   <= w_tag;
      end
    end
  end

  assign req_ready_o = r_live && (r_state == ST_IDLE);
  assign done_o      = (r_state == ST_DONE);
  assign mbus_cmd_o  = r_mbus_cmd;
  assign mbus_addr_o = r_mbus_addr;
  assign cbus_ack_o  = w_snp_ack;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// tb/tb_mesi_isc_cpu_agent.sv - directed scoreboard bench for mesi_isc_cpu_agent
module tb_mesi_isc_cpu_agent;
  import mesi_isc_pkg::*;

  localparam int AW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_wr_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic          req_ready_o;
  logic          done_o;
  logic [2:0]    mbus_cmd_o;
  logic [AW-1:0] mbus_addr_o;
  logic          mbus_ack_i = 1'b0;
  logic [2:0]    cbus_cmd_i = 3'd0;
  logic [AW-1:0] cbus_addr_i = '0;
  logic          cbus_ack_o;
  logic          err_o;

  always #5 clk = ~clk;

  mesi_isc_cpu_agent #(
    .ADDR_WIDTH (AW),
    .NUM_LINES  (4),
    .SNOOP_LAT  (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_wr_i    (req_wr_i),
    .req_addr_i  (req_addr_i),
    .req_ready_o (req_ready_o),
    .done_o      (done_o),
    .mbus_cmd_o  (mbus_cmd_o),
    .mbus_addr_o (mbus_addr_o),
    .mbus_ack_i  (mbus_ack_i),
    .cbus_cmd_i  (cbus_cmd_i),
    .cbus_addr_i (cbus_addr_i),
    .cbus_ack_o  (cbus_ack_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] addr;
  } mbus_exp_t;

  mbus_exp_t exp_q[$];
  mbus_exp_t cur_exp;
  int        n_chk  = 0;
  int        n_fail = 0;
  int        n_done = 0;
  int        done_before;
  logic      prev_ack = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) if (done_o) n_done++;

  always @(negedge clk) begin
    if (rst) chk("mbus_cmd_range", 64'(mbus_cmd_o <= MBUS_RD_BROAD), 64'd1);
    if (cbus_ack_o) chk("cbus_ack_gap", 64'(prev_ack), 64'd0);
    prev_ack = cbus_ack_o;
  end

  task automatic push_exp(input logic [2:0] cmd, input logic [31:0] addr);
    mbus_exp_t e;
    e.cmd  = cmd;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic cpu_req(input string tag, input logic wr, input logic [31:0] addr);
    int cyc = 0;
    req_valid_i = 1'b1;
    req_wr_i    = wr;
    req_addr_i  = addr;
    while (!req_ready_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    chk({tag, "_busy"}, 64'(req_ready_o), 64'd0);
  endtask

  task automatic mbus_expect(input string tag);
    int cyc = 0;
    while (mbus_cmd_o == MBUS_NOP && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_seen"}, 64'(cyc < 20), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
      cur_exp = '0;
    end else begin
      cur_exp = exp_q.pop_front();
    end
    chk({tag, "_cmd"}, 64'(mbus_cmd_o), 64'(cur_exp.cmd));
    chk({tag, "_addr"}, 64'(mbus_addr_o), 64'(cur_exp.addr));
  endtask

  task automatic mbus_ack(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_held"}, 64'({mbus_cmd_o, mbus_addr_o}), 64'({cur_exp.cmd, cur_exp.addr}));
    mbus_ack_i = 1'b1;
    @(negedge clk);
    mbus_ack_i = 1'b0;
    chk({tag, "_nop_after_ack"}, 64'(mbus_cmd_o), 64'(MBUS_NOP));
    chk({tag, "_addr_kept"}, 64'(mbus_addr_o), 64'(cur_exp.addr));
  endtask

  task automatic cbus_send(input string tag, input logic [2:0] cmd, input logic [31:0] addr,
                           input logic exp_err);
    int cyc = 0;
    cbus_cmd_i  = cmd;
    cbus_addr_i = addr;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cbus_ack_o && cyc < 20);
    cbus_cmd_i = CBUS_NOP;
    chk({tag, "_ack_lat"}, 64'(cyc), 64'(LAT));
    @(negedge clk);
    chk({tag, "_ack_width"}, 64'(cbus_ack_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    @(negedge clk);
    chk({tag, "_done_width"}, 64'(done_o), 64'd0);
    chk({tag, "_idle"}, 64'(req_ready_o), 64'd1);
  endtask

  task automatic hit_fast(input string tag, input logic wr, input logic [31:0] addr);
    cpu_req(tag, wr, addr);
    chk({tag, "_c1"}, 64'({done_o, mbus_cmd_o}), 64'({1'b0, MBUS_NOP}));
    @(negedge clk);
    chk({tag, "_c2"}, 64'({done_o, mbus_cmd_o}), 64'({1'b1, MBUS_NOP}));
    @(negedge clk);
    chk({tag, "_c3"}, 64'({done_o, mbus_cmd_o}), 64'({1'b0, MBUS_NOP}));
  endtask

  task automatic miss_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic exp_err);
    push_exp(wr ? MBUS_WR_BROAD : MBUS_RD_BROAD, addr);
    push_exp(wr ? MBUS_WR : MBUS_RD, addr);
    cpu_req(tag, wr, addr);
    mbus_expect({tag, "_broad"});
    mbus_ack({tag, "_broad"});
    cbus_send({tag, "_en"}, wr ? CBUS_EN_WR : CBUS_EN_RD, addr, exp_err);
    mbus_expect({tag, "_access"});
    mbus_ack({tag, "_access"});
    wait_done(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({mbus_cmd_o, mbus_addr_o, cbus_ack_o, done_o, err_o, req_ready_o}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(req_ready_o), 64'd1);

    miss_txn("rd_miss_10", 1'b0, 32'h10, 1'b0);
    hit_fast("rd_hit_10", 1'b0, 32'h10);

    miss_txn("wr_shared_10", 1'b1, 32'h10, 1'b0);
    hit_fast("wr_hit_m_10", 1'b1, 32'h10);

    cbus_send("wr_snoop_10", CBUS_WR_SNOOP, 32'h10, 1'b0);
    miss_txn("rd_after_inv_10", 1'b0, 32'h10, 1'b0);

    cbus_send("en_wr_idle", CBUS_EN_WR, 32'h20, 1'b1);
    chk("ready_after_stray_en", 64'(req_ready_o), 64'd1);
    repeat (4) @(negedge clk);
    chk("err_sticky", 64'(err_o), 64'd1);

    push_exp(MBUS_WR_BROAD, 32'h20);
    push_exp(MBUS_WR, 32'h20);
    cpu_req("wr_miss_20", 1'b1, 32'h20);
    mbus_expect("wr_miss_20_broad");
    cbus_send("rd_snoop_14_busy", CBUS_RD_SNOOP, 32'h14, 1'b1);
    mbus_ack("wr_miss_20_broad");
    cbus_send("wr_miss_20_en", CBUS_EN_WR, 32'h20, 1'b1);
    mbus_expect("wr_miss_20_access");
    mbus_ack("wr_miss_20_access");
    wait_done("wr_miss_20");
    hit_fast("wr_hit_m_20", 1'b1, 32'h20);

    cbus_send("rd_snoop_20", CBUS_RD_SNOOP, 32'h20, 1'b1);
    miss_txn("wr_after_share_20", 1'b1, 32'h20, 1'b1);

    push_exp(MBUS_RD_BROAD, 32'h30);
    cpu_req("rd_miss_30", 1'b0, 32'h30);
    mbus_expect("rd_miss_30_broad");
    mbus_ack("rd_miss_30_broad");
    rst = 1'b0;
    #1;
    chk("midtxn_reset_outputs",
        64'({mbus_cmd_o, mbus_addr_o, cbus_ack_o, done_o, err_o, req_ready_o}), 64'd0);
    done_before = n_done;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", 64'(n_done), 64'(done_before));
    chk("ready_after_abort", 64'(req_ready_o), 64'd1);

    miss_txn("rd_after_reset_20", 1'b0, 32'h20, 1'b0);

    cbus_send("bad_cmd7", 3'd7, 32'h20, 1'b1);
    hit_fast("rd_hit_after_bad", 1'b0, 32'h20);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
